// File: rtl/rsp_read_pkg.sv
// Shared types and constants for the SD CMD-line response receiver.
// The state enum, frame geometry, error record and CRC7 step used by rsp_receiver and crc7_read.
package rsp_read_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_START,
        RECEIVE,
        DONE
    } rsp_state_e;

    localparam int unsigned RspShortBits  = 48;
    localparam int unsigned RspLongBits   = 136;
    localparam int unsigned CrcShortFirst = 47;
    localparam int unsigned CrcLongFirst  = 127;
    localparam int unsigned CrcLast       = 8;

    typedef struct packed {
        logic timeout;
        logic crc;
        logic end_bit;
        logic index;
    } rsp_err_t;

    // One serial step of CRC7, generator x^7 + x^3 + 1, data MSB first.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = crc[6] ^ din;
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

endpackage

// File: rtl/crc7_read.sv
// Serial CRC7 accumulator for the response path.
// The start pulse is internally delayed two enabled cycles to line up with the caller's delay line.
module crc7_read
    import rsp_read_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clk_en_i,
    input  logic       start_i,
    input  logic       rsp_ser_i,
    input  logic       end_output_i,
    output logic [6:0] crc7_o
);

    logic [1:0] start_pipe_q, start_pipe_d;
    logic       active_q, active_d;
    logic [6:0] crc_q, crc_d;

    always_comb begin
        start_pipe_d = start_pipe_q;
        active_d     = active_q;
        crc_d        = crc_q;
        if (clk_en_i) begin
            start_pipe_d = {start_pipe_q[0], start_i};
            if (start_pipe_q[1]) begin
                // First covered bit has reached rsp_ser_i: restart from zero.
                crc_d    = crc7_step(7'h00, rsp_ser_i);
                active_d = !end_output_i;
            end else if (active_q) begin
                crc_d = crc7_step(crc_q, rsp_ser_i);
                if (end_output_i) begin
                    active_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            start_pipe_q <= '0;
            active_q     <= 1'b0;
            crc_q        <= '0;
        end else begin
            start_pipe_q <= start_pipe_d;
            active_q     <= active_d;
            crc_q        <= crc_d;
        end
    end

    assign crc7_o = crc_q;

endmodule

// File: rtl/rsp_receiver.sv
// SD CMD-line response sequencer: waits for the start bit, shifts in a 48- or 136-bit response,
// and reports CRC7, end-bit, index and NCR-timeout errors alongside a one-cycle done_o.
module rsp_receiver
    import rsp_read_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clk_en_i,
    input  logic         start_i,
    input  logic         rsp_long_i,
    input  logic         check_crc_i,
    input  logic         check_index_i,
    input  logic [5:0]   cmd_index_i,
    input  logic         cmd_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [119:0] rsp_o,
    output logic [5:0]   rsp_index_o,
    output logic         timeout_err_o,
    output logic         crc_err_o,
    output logic         end_bit_err_o,
    output logic         index_err_o
);

    localparam logic [7:0] TimeoutLimit = 8'(TimeoutCycles);
    localparam logic [7:0] LongFirstCnt = 8'(RspLongBits - 2);
    localparam logic [7:0] ShortFirstCnt = 8'(RspShortBits - 2);
    localparam logic [7:0] CrcLongCnt   = 8'(CrcLongFirst);
    localparam logic [7:0] CrcLastCnt   = 8'(CrcLast);
    localparam logic [7:0] CrcEndCnt    = 8'(CrcLast - 2);
    localparam logic [7:0] ArgHiCnt     = 8'd39;
    localparam logic [7:0] IdxLoCnt     = 8'd40;
    localparam logic [7:0] IdxHiCnt     = 8'd45;
    localparam logic [7:0] CrcRxHiCnt   = 8'd7;

    rsp_state_e   state_q, state_d;
    logic [7:0]   tcnt_q, tcnt_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         long_q, long_d;
    logic         chk_crc_q, chk_crc_d;
    logic         chk_idx_q, chk_idx_d;
    logic [5:0]   exp_idx_q, exp_idx_d;
    logic [119:0] sr_q, sr_d;
    logic [5:0]   idx_q, idx_d;
    logic [6:0]   crc_rx_q, crc_rx_d;
    rsp_err_t     err_q, err_d;
    logic [1:0]   dly_q, dly_d;

    logic         crc_start;
    logic         crc_end;
    logic [6:0]   crc7;
    logic [7:0]   tcnt_inc;
    logic [7:0]   sr_hi_cnt;

    assign tcnt_inc  = tcnt_q + 8'd1;
    assign sr_hi_cnt = long_q ? CrcLongCnt : ArgHiCnt;

    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        cnt_d     = cnt_q;
        long_d    = long_q;
        chk_crc_d = chk_crc_q;
        chk_idx_d = chk_idx_q;
        exp_idx_d = exp_idx_q;
        sr_d      = sr_q;
        idx_d     = idx_q;
        crc_rx_d  = crc_rx_q;
        err_d     = err_q;
        dly_d     = dly_q;
        crc_start = 1'b0;
        crc_end   = 1'b0;
        done_o    = 1'b0;

        if (clk_en_i) begin
            dly_d = {dly_q[0], cmd_i};
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d   = WAIT_START;
                        // The accepting cycle counts as the first of the NCR window.
                        tcnt_d    = 8'd1;
                        long_d    = rsp_long_i;
                        chk_crc_d = check_crc_i;
                        chk_idx_d = check_index_i;
                        exp_idx_d = cmd_index_i;
                        sr_d      = '0;
                        idx_d     = '0;
                        crc_rx_d  = '0;
                        err_d     = '0;
                    end
                end
                WAIT_START: begin
                    if (!cmd_i) begin
                        state_d   = RECEIVE;
                        // Start bit is bit N-1; the counter holds the index of the next bit.
                        cnt_d     = long_q ? LongFirstCnt : ShortFirstCnt;
                        crc_start = !long_q;
                    end else begin
                        tcnt_d = tcnt_inc;
                        if (tcnt_inc == TimeoutLimit) begin
                            state_d       = DONE;
                            err_d         = '0;
                            err_d.timeout = 1'b1;
                        end
                    end
                end
                RECEIVE: begin
                    cnt_d     = cnt_q - 8'd1;
                    crc_start = long_q && (cnt_q == CrcLongCnt);
                    crc_end   = (cnt_q == CrcEndCnt);
                    if (cnt_q >= CrcLastCnt && cnt_q <= sr_hi_cnt) begin
                        sr_d = {sr_q[118:0], cmd_i};
                    end
                    if (!long_q && cnt_q >= IdxLoCnt && cnt_q <= IdxHiCnt) begin
                        idx_d = {idx_q[4:0], cmd_i};
                    end
                    if (cnt_q >= 8'd1 && cnt_q <= CrcRxHiCnt) begin
                        crc_rx_d = {crc_rx_q[5:0], cmd_i};
                    end
                    if (cnt_q == 8'd0) begin
                        // CRC finished at bit 8, so the verdict is registered here and valid with done_o.
                        state_d       = DONE;
                        err_d.timeout = 1'b0;
                        err_d.end_bit = !cmd_i;
                        err_d.crc     = chk_crc_q && (crc7 != crc_rx_q);
                        err_d.index   = chk_idx_q && !long_q && (idx_q != exp_idx_q);
                    end
                end
                DONE: begin
                    done_o  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            tcnt_q    <= '0;
            cnt_q     <= '0;
            long_q    <= 1'b0;
            chk_crc_q <= 1'b0;
            chk_idx_q <= 1'b0;
            exp_idx_q <= '0;
            sr_q      <= '0;
            idx_q     <= '0;
            crc_rx_q  <= '0;
            err_q     <= '0;
            dly_q     <= '1;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            cnt_q     <= cnt_d;
            long_q    <= long_d;
            chk_crc_q <= chk_crc_d;
            chk_idx_q <= chk_idx_d;
            exp_idx_q <= exp_idx_d;
            sr_q      <= sr_d;
            idx_q     <= idx_d;
            crc_rx_q  <= crc_rx_d;
            err_q     <= err_d;
            dly_q     <= dly_d;
        end
    end

    crc7_read u_crc7 (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clk_en_i     (clk_en_i),
        .start_i      (crc_start),
        .rsp_ser_i    (dly_q[1]),
        .end_output_i (crc_end),
        .crc7_o       (crc7)
    );

    assign busy_o        = (state_q != IDLE);
    assign rsp_o         = sr_q;
    assign rsp_index_o   = idx_q;
    assign timeout_err_o = err_q.timeout;
    assign crc_err_o     = err_q.crc;
    assign end_bit_err_o = err_q.end_bit;
    assign index_err_o   = err_q.index;

endmodule

// File: tb/tb_rsp_receiver.sv
// Directed bench for rsp_receiver: short/long frames, CRC/end/index errors, timeout,
// clock-enable gating and asynchronous reset mid-frame.
module tb_rsp_receiver;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         clk_en_i;
    logic         start_i;
    logic         rsp_long_i;
    logic         check_crc_i;
    logic         check_index_i;
    logic [5:0]   cmd_index_i;
    logic         cmd_i;
    logic         busy_o;
    logic         done_o;
    logic [119:0] rsp_o;
    logic [5:0]   rsp_index_o;
    logic         timeout_err_o;
    logic         crc_err_o;
    logic         end_bit_err_o;
    logic         index_err_o;

    int checks = 0;
    int errors = 0;
    int en_period = 1;
    int spurious_done = 0;

    rsp_receiver #(.TimeoutCycles(64)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clk_en_i      (clk_en_i),
        .start_i       (start_i),
        .rsp_long_i    (rsp_long_i),
        .check_crc_i   (check_crc_i),
        .check_index_i (check_index_i),
        .cmd_index_i   (cmd_index_i),
        .cmd_i         (cmd_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .rsp_o         (rsp_o),
        .rsp_index_o   (rsp_index_o),
        .timeout_err_o (timeout_err_o),
        .crc_err_o     (crc_err_o),
        .end_bit_err_o (end_bit_err_o),
        .index_err_o   (index_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] errs();
        return {timeout_err_o, crc_err_o, end_bit_err_o, index_err_o};
    endfunction

    // CRC7 as polynomial long division of msg(x)*x^7 by x^7+x^3+1.
    function automatic logic [6:0] crc7_div(input logic [119:0] msg, input int n);
        logic [126:0] r;
        r = {msg, 7'b0};
        for (int i = n + 6; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    function automatic logic [135:0] mk_short(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] m;
        m = {2'b00, idx, arg};
        return {88'b0, m, crc7_div(120'(m), 40), 1'b1};
    endfunction

    function automatic logic [135:0] mk_long(input logic [119:0] payload);
        return {8'h3F, payload, crc7_div(payload, 120), 1'b1};
    endfunction

    // One enabled SD cycle, preceded by en_period-1 disabled clocks; d = done_o in the enabled cycle.
    task automatic cyc(output logic d);
        for (int k = 1; k < en_period; k++) begin
            clk_en_i = 1'b0;
            #1;
            if (done_o) spurious_done++;
            @(posedge clk_i);
            #1;
        end
        clk_en_i = 1'b1;
        #1;
        d = done_o;
        @(posedge clk_i);
        #1;
    endtask

    // Accept start_i, idle for gap cycles, then send the frame; ok = done exactly after the last bit.
    task automatic run_frame(input logic [135:0] frame, input logic long_f, input logic ccrc,
                             input logic cidx, input logic [5:0] eidx, input int gap,
                             input logic busy_start, output logic ok);
        logic d;
        int n;
        int early;
        n = long_f ? 136 : 48;
        early = 0;
        cmd_i = 1'b1;
        rsp_long_i = long_f;
        check_crc_i = ccrc;
        check_index_i = cidx;
        cmd_index_i = eidx;
        start_i = 1'b1;
        cyc(d);
        start_i = 1'b0;
        if (d) early++;
        for (int g = 0; g < gap; g++) begin
            cyc(d);
            if (d) early++;
        end
        for (int i = n - 1; i >= 0; i--) begin
            cmd_i = frame[i];
            if (busy_start && i == 30) begin
                start_i = 1'b1;
                rsp_long_i = ~long_f;
                check_crc_i = 1'b0;
                cmd_index_i = ~eidx;
            end
            cyc(d);
            start_i = 1'b0;
            rsp_long_i = long_f;
            check_crc_i = ccrc;
            cmd_index_i = eidx;
            if (d) early++;
        end
        cmd_i = 1'b1;
        cyc(d);
        ok = d && (early == 0);
    endtask

    logic [135:0] f1;
    logic [135:0] fr;
    logic [119:0] cid;
    logic         ok;
    logic         d;
    int           tcount;
    logic         got;

    initial begin
        rst_ni = 1'b0;
        clk_en_i = 1'b1;
        start_i = 1'b0;
        rsp_long_i = 1'b0;
        check_crc_i = 1'b1;
        check_index_i = 1'b1;
        cmd_index_i = 6'd17;
        cmd_i = 1'b1;
        f1 = mk_short(6'd17, 32'h0000_0900);
        cid = 120'h03_5344_5344_3136_4780_1234_5678_0142;

        #12;
        chk("reset_busy", busy_o, 0);
        chk("reset_done", done_o, 0);
        chk("reset_rsp", rsp_o, 0);
        chk("reset_errs", errs(), 4'b0000);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // R1 index 17, arg 0x900
        run_frame(f1, 1'b0, 1'b1, 1'b1, 6'd17, 0, 1'b0, ok);
        chk("r1_done_49", ok, 1);
        chk("r1_rsp", rsp_o, 120'h900);
        chk("r1_index", rsp_index_o, 6'd17);
        chk("r1_errs", errs(), 4'b0000);
        chk("r1_idle", busy_o, 0);

        // CRC bit flipped
        fr = f1;
        fr[3] = ~fr[3];
        run_frame(fr, 1'b0, 1'b1, 1'b1, 6'd17, 0, 1'b0, ok);
        chk("crc_flip_done", ok, 1);
        chk("crc_flip_errs", errs(), 4'b0100);
        chk("crc_flip_rsp", rsp_o, 120'h900);

        // Index mismatch
        run_frame(f1, 1'b0, 1'b1, 1'b1, 6'd18, 0, 1'b0, ok);
        chk("idx_mis_errs", errs(), 4'b0001);

        // R3: CRC field all ones, not checked
        fr = {88'b0, 2'b00, 6'h3F, 32'hDEAD_BEEF, 7'h7F, 1'b1};
        run_frame(fr, 1'b0, 1'b0, 1'b0, 6'd0, 0, 1'b0, ok);
        chk("r3_done", ok, 1);
        chk("r3_errs", errs(), 4'b0000);
        chk("r3_rsp", rsp_o, 120'hDEAD_BEEF);
        chk("r3_index", rsp_index_o, 6'h3F);

        // R2 CID
        fr = mk_long(cid);
        run_frame(fr, 1'b1, 1'b1, 1'b1, 6'd2, 0, 1'b0, ok);
        chk("r2_done", ok, 1);
        chk("r2_rsp", rsp_o, cid);
        chk("r2_index", rsp_index_o, 6'd0);
        chk("r2_errs", errs(), 4'b0000);
        fr[64] = ~fr[64];
        run_frame(fr, 1'b1, 1'b1, 1'b1, 6'd2, 0, 1'b0, ok);
        chk("r2_bad_errs", errs(), 4'b0100);
        chk("r2_bad_rsp", rsp_o, cid ^ (120'd1 << 56));

        // Timeout: cmd_i stays high
        cmd_i = 1'b1;
        start_i = 1'b1;
        cyc(d);
        start_i = 1'b0;
        tcount = 0;
        got = 1'b0;
        for (int k = 1; k <= 200 && !got; k++) begin
            cyc(d);
            if (d) begin
                got = 1'b1;
                tcount = k;
            end
        end
        chk("timeout_cycles", tcount, 64);
        chk("timeout_errs", errs(), 4'b1000);
        chk("timeout_idle", busy_o, 0);

        // Start bit on the timeout cycle wins
        run_frame(f1, 1'b0, 1'b1, 1'b1, 6'd17, 62, 1'b0, ok);
        chk("late_start_done", ok, 1);
        chk("late_start_errs", errs(), 4'b0000);
        chk("late_start_rsp", rsp_o, 120'h900);

        // clk_en_i high one cycle in four
        en_period = 4;
        spurious_done = 0;
        run_frame(f1, 1'b0, 1'b1, 1'b1, 6'd17, 0, 1'b0, ok);
        en_period = 1;
        chk("gated_done", ok, 1);
        chk("gated_no_stray_done", spurious_done, 0);
        chk("gated_rsp", rsp_o, 120'h900);
        chk("gated_index", rsp_index_o, 6'd17);
        chk("gated_errs", errs(), 4'b0000);

        // End bit low
        fr = f1;
        fr[0] = 1'b0;
        run_frame(fr, 1'b0, 1'b1, 1'b1, 6'd17, 0, 1'b0, ok);
        chk("endbit_errs", errs(), 4'b0010);

        // Asynchronous reset mid-RECEIVE
        cmd_i = 1'b1;
        start_i = 1'b1;
        cyc(d);
        start_i = 1'b0;
        for (int i = 47; i >= 28; i--) begin
            cmd_i = f1[i];
            cyc(d);
        end
        chk("pre_reset_busy", busy_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_errs", errs(), 4'b0000);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        cmd_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Valid frame after reset, with an ignored start_i mid-frame
        run_frame(f1, 1'b0, 1'b1, 1'b1, 6'd17, 0, 1'b1, ok);
        chk("post_rst_done", ok, 1);
        chk("post_rst_rsp", rsp_o, 120'h900);
        chk("post_rst_index", rsp_index_o, 6'd17);
        chk("post_rst_errs", errs(), 4'b0000);
        chk("post_rst_idle", busy_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
